// File: rtl/bank_fifo_write_arb.sv
// Two-requester burst arbiter for the BankFifo write port.
// Grants whole bursts of BURST_LEN words, round-robin between bursts.
module bank_fifo_write_arb #(
  parameter int W         = 16,
  parameter int BURST_LEN = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  output logic         ack0,
  output logic         ack1,
  output logic [1:0]   grant,
  output logic         fifo_w_trigger,
  output logic [W-1:0] fifo_w_data,
  input  logic         fifo_w_done,
  output logic         burst_done,
  output logic [15:0]  burst_cnt0,
  output logic [15:0]  burst_cnt1,
  output logic         err
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic          rr;
  logic          take;
  logic          last;
  logic [1:0]    pick;

  always_comb begin
    fifo_w_trigger = (grant[0] & req0) | (grant[1] & req1);
    fifo_w_data    = '0;
    case (grant)
      2'b01:   fifo_w_data = data0;
      2'b10:   fifo_w_data = data1;
      default: fifo_w_data = '0;
    endcase
    // a done without a trigger is a protocol error, never an accept
    take       = fifo_w_done & fifo_w_trigger;
    ack0       = take & grant[0];
    ack1       = take & grant[1];
    last       = (wcnt == LAST);
    burst_done = take & last;
    pick       = {req1 & (~req0 | rr),
                  req0 & (~req1 | ~rr)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      wcnt       <= '0;
      rr         <= 1'b0;
      burst_cnt0 <= 16'd0;
      burst_cnt1 <= 16'd0;
      err        <= 1'b0;
    end else begin
      if (fifo_w_done & ~fifo_w_trigger)
        err <= 1'b1;
      case (state)
        IDLE: begin
          if (|pick) begin
            grant <= pick;
            wcnt  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (take) begin
            if (last) begin
              wcnt  <= '0;
              grant <= 2'b00;
              rr    <= grant[0];
              state <= IDLE;
              if (grant[0])
                burst_cnt0 <= burst_cnt0 + 16'd1;
              else
                burst_cnt1 <= burst_cnt1 + 16'd1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_fifo_write_arb.sv
// Directed bench for bank_fifo_write_arb with BURST_LEN = 4.
// Expected FIFO words are queued up front and popped on each accept.
module tb_bank_fifo_write_arb;

  localparam int W  = 16;
  localparam int BL = 4;

  logic         clk;
  logic         rst;
  logic         req0;
  logic         req1;
  logic [W-1:0] data0;
  logic [W-1:0] data1;
  logic         ack0;
  logic         ack1;
  logic [1:0]   grant;
  logic         fifo_w_trigger;
  logic [W-1:0] fifo_w_data;
  logic         fifo_w_done;
  logic         burst_done;
  logic [15:0]  burst_cnt0;
  logic [15:0]  burst_cnt1;
  logic         err;

  bank_fifo_write_arb #(.W(W), .BURST_LEN(BL)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .req1           (req1),
    .data0          (data0),
    .data1          (data1),
    .ack0           (ack0),
    .ack1           (ack1),
    .grant          (grant),
    .fifo_w_trigger (fifo_w_trigger),
    .fifo_w_data    (fifo_w_data),
    .fifo_w_done    (fifo_w_done),
    .burst_done     (burst_done),
    .burst_cnt0     (burst_cnt0),
    .burst_cnt1     (burst_cnt1),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int bd_cnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;

  logic [1:0]  s_grant;
  logic        s_trig;
  logic        s_ack0;
  logic        s_ack1;
  logic        s_bd;
  logic        s_err;
  logic [15:0] s_c0;
  logic [15:0] s_c1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sample at negedge, then advance producers on the next edge
  task automatic cyc();
    @(negedge clk);
    s_grant = grant;
    s_trig  = fifo_w_trigger;
    s_ack0  = ack0;
    s_ack1  = ack1;
    s_bd    = burst_done;
    s_err   = err;
    s_c0    = burst_cnt0;
    s_c1    = burst_cnt1;
    if (s_bd) bd_cnt++;
    if (s_trig && fifo_w_done) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(fifo_w_data), 32'hDEAD);
      end else begin
        exp_w = exp_q.pop_front();
        chk("word", 32'(fifo_w_data), 32'(exp_w));
      end
    end
    @(posedge clk);
    #1;
    if (s_ack0) data0 = data0 + 16'd1;
    if (s_ack1) data1 = data1 + 16'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_w_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    data0  = 16'h0000;
    data1  = 16'h8000;
    bd_cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bd_cnt = 0;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    data0 = '0;
    data1 = '0;
    fifo_w_done = 1'b0;

    // reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_trig", 32'(fifo_w_trigger), 32'd0);
    chk("rst_data", 32'(fifo_w_data), 32'd0);
    chk("rst_ack", 32'({ack1, ack0}), 32'd0);
    chk("rst_bd", 32'(burst_done), 32'd0);
    chk("rst_cnt0", 32'(burst_cnt0), 32'd0);
    chk("rst_cnt1", 32'(burst_cnt1), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // single requester, done always high
    req0 = 1'b1;
    fifo_w_done = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(i));
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("single_grant", 32'(s_grant),
          (c % 5 == 0) ? 32'd0 : 32'd1);
    end
    req0 = 1'b0;
    fifo_w_done = 1'b0;
    chk("single_bd", 32'(bd_cnt), 32'd2);
    chk("single_cnt0", 32'(burst_cnt0), 32'd2);
    chk("single_cnt1", 32'(burst_cnt1), 32'd0);
    chk("single_q", 32'(exp_q.size()), 32'd0);

    // contention, both held from reset
    req0 = 1'b1;
    req1 = 1'b1;
    do_reset();
    fifo_w_done = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(W'(4 * b + i));
      for (int i = 0; i < 4; i++)
        exp_q.push_back(W'(16'h8000 + 4 * b + i));
    end
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk("cont_grant", 32'(s_grant),
          (c % 5 == 0) ? 32'd0 :
          (((c / 5) % 2) == 0) ? 32'd1 : 32'd2);
      chk("cont_ack_excl", 32'(s_ack0 & s_ack1), 32'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    fifo_w_done = 1'b0;
    chk("cont_cnt0", 32'(burst_cnt0), 32'd2);
    chk("cont_cnt1", 32'(burst_cnt1), 32'd2);
    chk("cont_q", 32'(exp_q.size()), 32'd0);

    // stall: req0 drops for 3 cycles after word 1
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(i));
    cyc();
    fifo_w_done = 1'b1;
    cyc();
    cyc();
    chk("stall_pre_grant", 32'(s_grant), 32'd1);
    req0 = 1'b0;
    fifo_w_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_trig", 32'(s_trig), 32'd0);
      chk("stall_grant", 32'(s_grant), 32'd1);
      chk("stall_ack1", 32'(s_ack1), 32'd0);
    end
    req0 = 1'b1;
    fifo_w_done = 1'b1;
    cyc();
    chk("stall_w2_bd", 32'(s_bd), 32'd0);
    cyc();
    chk("stall_w3_bd", 32'(s_bd), 32'd1);
    fifo_w_done = 1'b0;
    req0 = 1'b0;
    cyc();
    chk("stall_idle", 32'(s_grant), 32'd0);
    chk("stall_cnt0", 32'(s_c0), 32'd1);
    cyc();
    chk("stall_next", 32'(s_grant), 32'd2);
    chk("stall_err", 32'(s_err), 32'd0);
    chk("stall_q", 32'(exp_q.size()), 32'd0);
    req1 = 1'b0;

    // backpressure: done every other cycle
    do_reset();
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(i));
    cyc();
    for (int i = 1; i <= 8; i++) begin
      fifo_w_done = (i % 2 == 1);
      cyc();
      chk("bp_ack0", 32'(s_ack0), 32'(fifo_w_done));
      chk("bp_bd", 32'(s_bd), (i == 7) ? 32'd1 : 32'd0);
      if (i == 7) req0 = 1'b0;
    end
    fifo_w_done = 1'b0;
    cyc();
    chk("bp_cnt0", 32'(s_c0), 32'd1);
    chk("bp_q", 32'(exp_q.size()), 32'd0);

    // protocol error: spurious done in IDLE
    fifo_w_done = 1'b1;
    cyc();
    chk("perr_before", 32'(s_err), 32'd0);
    chk("perr_noack", 32'({s_ack1, s_ack0}), 32'd0);
    fifo_w_done = 1'b0;
    cyc();
    chk("perr_set", 32'(s_err), 32'd1);
    cyc();
    chk("perr_held", 32'(s_err), 32'd1);
    chk("perr_cnt0", 32'(s_c0), 32'd1);
    chk("perr_cnt1", 32'(s_c1), 32'd0);

    // reset mid-burst; rr was left pointing at req1
    exp_q.push_back(data0);
    exp_q.push_back(data0 + 16'd1);
    req0 = 1'b1;
    cyc();
    fifo_w_done = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    fifo_w_done = 1'b0;
    req1 = 1'b1;
    cyc();
    rst = 1'b0;
    data0 = 16'h0000;
    data1 = 16'h8000;
    cyc();
    chk("mrst_grant", 32'(s_grant), 32'd0);
    chk("mrst_trig", 32'(s_trig), 32'd0);
    chk("mrst_cnt0", 32'(s_c0), 32'd0);
    chk("mrst_cnt1", 32'(s_c1), 32'd0);
    chk("mrst_err", 32'(s_err), 32'd0);
    cyc();
    chk("mrst_rr", 32'(s_grant), 32'd1);
    chk("mrst_q", 32'(exp_q.size()), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bank_fifo_write_arb.md
# bank_fifo_write_arb

Two-requester arbiter that shares the single BankFifo write port (trigger/data/done handshake) between two producers, e.g. an image-pixel stream and a metadata stream. It grants the port for whole bursts of BURST_LEN words so that each requester's words occupy contiguous FIFO bank space. Round-robin between bursts keeps either requester from being starved. It sits in the BankFifo write clock domain, between the producers and the BankFifo write side.

## Interface
- W, 16, data word width; matches the BankFifo word width
- BURST_LEN, 128, words per grant; power of 2, minimum 2
- clk  in  1  write-domain clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  requester N has a word on dataN
- data0 / data1  in  W  requester N word
- ack0 / ack1  out  1  one-cycle pulse: requester N word accepted this cycle; requester advances its data on the next edge
- grant  out  2  one-hot current owner (2'b01 = req0, 2'b10 = req1, 0 = none)
- fifo_w_trigger  out  1  to BankFifo w_trigger
- fifo_w_data  out  W  to BankFifo w_data
- fifo_w_done  in  1  from BankFifo w_done; word accepted this cycle
- burst_done  out  1  one-cycle pulse on the last accepted word of a burst
- burst_cnt0 / burst_cnt1  out  16  completed bursts per requester; wraps 16'hFFFF -> 0
- err  out  1  sticky protocol error flag

## Operation
- States: IDLE, BURST. Registers: state, grant, word counter wcnt (log2(BURST_LEN) bits), round-robin pointer rr (0 = prefer req0).
- IDLE:
  - if no request, stay in IDLE, grant = 0;
  - if exactly one reqN is high, grant N;
  - if both are high, grant requester rr;
  - on a grant, go to BURST on the next edge with wcnt = 0.
- BURST (combinational outputs):
  - fifo_w_trigger = req of the granted requester;
  - fifo_w_data = data of the granted requester, otherwise all zeros;
  - ackN = fifo_w_done & grant[N].
- On fifo_w_done in BURST, wcnt increments.
- When fifo_w_done arrives and wcnt == BURST_LEN-1:
  - burst_done pulses;
  - burst_cntN increments;
  - rr = the other requester;
  - grant clears;
  - state returns to IDLE.
- Stall: if the granted requester drops req mid-burst:
  - trigger deasserts and wcnt holds;
  - grant is kept and is not revoked until the burst completes;
  - the other requester waits.
- err sets, and stays set until rst, when fifo_w_done = 1 while fifo_w_trigger = 0. The spurious done is otherwise ignored: no ack and no count.
- Reset mid-burst abandons the partial burst. No pad or flush. Producers are reset by the same rst.

## Timing
- Reset values: state = IDLE, grant = 0, wcnt = 0, rr = 0, burst_cnt0 = burst_cnt1 = 0, err = 0. fifo_w_trigger, fifo_w_data, ack0/1 and burst_done are all 0.
- Grant latency: req rising in IDLE at edge k gives grant and fifo_w_trigger high after edge k+1.
- Throughput: one word per cycle while fifo_w_done stays high. A burst takes BURST_LEN cycles at minimum.
- Gap between bursts is exactly one IDLE cycle. Sustained occupancy is BURST_LEN/(BURST_LEN+1).
- fifo_w_trigger, fifo_w_data and ackN are combinational from registered grant, req and data. No registered delay is added to the BankFifo handshake.
- burst_done coincides with the final ack. burst_cntN shows the new value one cycle later.
- Simultaneous events:
  - both reqs rising in the same cycle: the rr winner is granted;
  - new req arriving during BURST: ignored until IDLE;
  - stall on the final word: burst completes on the eventual done.

## Test plan
- Single requester: BURST_LEN = 4, req0 held, fifo_w_done always 1, data0 = 0,1,2,...
  - required: fifo_w_data = 0,1,2,3, then one idle cycle, then 4,5,6,7;
  - burst_done pulses twice; burst_cnt0 = 2; burst_cnt1 = 0.
- Contention: both reqs held from reset, BURST_LEN = 4.
  - required: grants alternate 01, 10, 01, 10 with one idle cycle between;
  - ack0 and ack1 never high in the same cycle; after 4 bursts, burst_cnt0 = burst_cnt1 = 2.
- Stall: req0 dropped for 3 cycles after word 1.
  - required: trigger low for those 3 cycles, wcnt holds at 2, grant stays 01 with req1 waiting;
  - burst finishes with words 2 and 3.
- Backpressure: fifo_w_done = 1 only every other cycle.
  - required: the burst of 4 completes after 8 cycles;
  - ack0 mirrors fifo_w_done.
- Protocol error: pulse fifo_w_done in IDLE.
  - required: err = 1 from the next cycle and held; counts unchanged.
- Reset mid-burst: assert rst after word 2.
  - required: next cycle grant = 0, trigger = 0, burst_cnt0 = burst_cnt1 = 0, err = 0, rr = 0.
